trdb_reg_bank: RTL

//  Software-programmable control/status register bank for the trace encoder.

---
 rtl/trdb_reg_bank.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/trdb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : trdb_reg_bank
//  Description : Control/status register bank for the trace encoder.
//                Holds CTRL/MASK/STAT/TOUT, runs one IDLE/TRACING/DRAIN
//                state machine per traced hart, drives the encoder
//                configuration outputs and gates the encoder clock.
//  Ports       : clk_i/rst_i             clock, synchronous active-high reset
//                reg_*                   single-cycle register port; response
//                                        (rdata/error) valid with reg_ready_o
//                trace_req_on_i/off_i    per-hart start/stop requests
//                flush_done_i            per-hart encoder flush complete
//                trace_enable_o/drain_o  per-hart TRACING / DRAIN indication
//                trace_activated_o, nocontext_o, notime_o, encoder_mode_o,
//                addr_mode_o             encoder configuration
//                clk_gated_o             gated encoder clock
//  Revision    : 1.0 - initial release
// ============================================================================
module trdb_reg_bank #(
    parameter int unsigned NUM_HARTS     = 1,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reg_req_i,
    input  logic                 reg_we_i,
    input  logic [ADDR_W-1:0]    reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_ready_o,
    output logic                 reg_error_o,
    input  logic [NUM_HARTS-1:0] trace_req_on_i,
    input  logic [NUM_HARTS-1:0] trace_req_off_i,
    input  logic [NUM_HARTS-1:0] flush_done_i,
    output logic [NUM_HARTS-1:0] trace_enable_o,
    output logic [NUM_HARTS-1:0] drain_o,
    output logic                 trace_activated_o,
    output logic                 nocontext_o,
    output logic                 notime_o,
    output logic                 encoder_mode_o,
    output logic [1:0]           addr_mode_o,
    output logic                 clk_gated_o
);

    localparam int unsigned CNT_W     = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    // STAT only has room for 16 two-bit hart fields.
    localparam int unsigned STAT_BITS = (2 * NUM_HARTS > 32) ? 32 : 2 * NUM_HARTS;

    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(32'h0);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'h4);
    localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(32'h8);
    localparam logic [ADDR_W-1:0] ADDR_TOUT = ADDR_W'(32'hC);

    // Encoding chosen so bit 0 is "tracing" and bit 1 is "draining": the
    // per-hart outputs come straight off the state flops.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_TRACING = 2'b01,
        ST_DRAIN   = 2'b10
    } hart_state_e;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic                 act_q, act_d;
    logic                 noctx_q, noctx_d;
    logic                 notime_q, notime_d;
    logic                 full_q, full_d;
    logic [NUM_HARTS-1:0] mask_q, mask_d;
    logic [NUM_HARTS-1:0] tout_q, tout_d;

    logic                 ready_q;
    logic                 error_q;
    logic [31:0]          rdata_q;

    logic                 wr_w;
    logic                 sel_ctrl_w, sel_mask_w, sel_stat_w, sel_tout_w;
    logic                 mapped_w;
    logic                 sw_start_w, sw_stop_w;
    logic [NUM_HARTS-1:0] tout_clr_w;
    logic [NUM_HARTS-1:0] tout_set_w;
    logic [NUM_HARTS-1:0] busy_w;
    logic [2*NUM_HARTS-1:0] state_vec_w;
    logic [31:0]          stat_w;
    logic [31:0]          rdata_w;

    logic                 unused_wdata;
    assign unused_wdata = ^reg_wdata_i;

    // ------------------------------------------------------------------
    // Address decode and next register values
    // ------------------------------------------------------------------
    always_comb begin
        wr_w       = reg_req_i & reg_we_i;
        sel_ctrl_w = (reg_addr_i == ADDR_CTRL);
        sel_mask_w = (reg_addr_i == ADDR_MASK);
        sel_stat_w = (reg_addr_i == ADDR_STAT);
        sel_tout_w = (reg_addr_i == ADDR_TOUT);
        mapped_w   = sel_ctrl_w | sel_mask_w | sel_stat_w | sel_tout_w;

        act_d    = act_q;
        noctx_d  = noctx_q;
        notime_d = notime_q;
        full_d   = full_q;
        mask_d   = mask_q;
        if (wr_w && sel_ctrl_w) begin
            act_d    = reg_wdata_i[0];
            noctx_d  = reg_wdata_i[1];
            notime_d = reg_wdata_i[2];
            full_d   = reg_wdata_i[3];
        end
        if (wr_w && sel_mask_w) begin
            mask_d = reg_wdata_i[NUM_HARTS-1:0];
        end

        // SW_START / SW_STOP are pulses, never stored.
        sw_start_w = wr_w & sel_ctrl_w & reg_wdata_i[4];
        sw_stop_w  = wr_w & sel_ctrl_w & reg_wdata_i[5];

        tout_clr_w = (wr_w && sel_tout_w) ? reg_wdata_i[NUM_HARTS-1:0] : '0;
        // A timeout in the same cycle as a clear wins.
        tout_d     = (tout_q & ~tout_clr_w) | tout_set_w;
    end

    // ------------------------------------------------------------------
    // Read mux (values before this cycle's write)
    // ------------------------------------------------------------------
    always_comb begin
        stat_w = '0;
        for (int i = 0; i < STAT_BITS; i++) begin
            stat_w[i] = state_vec_w[i];
        end

        rdata_w = '0;
        if (sel_ctrl_w) rdata_w = {28'b0, full_q, notime_q, noctx_q, act_q};
        if (sel_mask_w) rdata_w = 32'(mask_q);
        if (sel_stat_w) rdata_w = stat_w;
        if (sel_tout_w) rdata_w = 32'(tout_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q    <= 1'b0;
            noctx_q  <= 1'b0;
            notime_q <= 1'b0;
            full_q   <= 1'b0;
            mask_q   <= '1;
            tout_q   <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            act_q    <= act_d;
            noctx_q  <= noctx_d;
            notime_q <= notime_d;
            full_q   <= full_d;
            mask_q   <= mask_d;
            tout_q   <= tout_d;
            ready_q  <= reg_req_i;
            error_q  <= reg_req_i & ~mapped_w;
            rdata_q  <= reg_req_i ? rdata_w : '0;
        end
    end

    // ------------------------------------------------------------------
    // Per-hart tracing state machines
    // ------------------------------------------------------------------
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        hart_state_e      state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             start_w;
        logic             stop_w;
        logic             expire_w;

        // Both terms use the register values as they will be after this
        // cycle's write, so a single CTRL write can enable and start.
        assign start_w  = act_d & mask_d[h] & (trace_req_on_i[h] | sw_start_w);
        assign stop_w   = trace_req_off_i[h] | sw_stop_w | ~act_d | ~mask_d[h];
        assign expire_w = (cnt_q == CNT_LAST);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_w && !stop_w) begin
                            state_q <= ST_TRACING;
                        end
                    end
                    ST_TRACING: begin
                        if (stop_w) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (flush_done_i[h] || expire_w) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign tout_set_w[h]         = (state_q == ST_DRAIN) & expire_w & ~flush_done_i[h];
        assign busy_w[h]             = (state_q != ST_IDLE);
        assign trace_enable_o[h]     = state_q[0];
        assign drain_o[h]            = state_q[1];
        assign state_vec_w[2*h +: 2] = state_q;
    end

    // ------------------------------------------------------------------
    // Encoder clock gate (test enable tied low). The enable is captured
    // while clk_i is low, so it can only change between pulses and the
    // gated clock never glitches. A draining hart keeps it running even
    // after ACT has been cleared.
    // ------------------------------------------------------------------
    logic gate_en_w;
    logic gate_en_q;

    assign gate_en_w = act_q | (|busy_w);

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            gate_en_q <= 1'b0;
        end else begin
            gate_en_q <= gate_en_w;
        end
    end

    assign clk_gated_o = clk_i & gate_en_q;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign reg_rdata_o       = rdata_q;
    assign reg_ready_o       = ready_q;
    assign reg_error_o       = error_q;
    assign trace_activated_o = act_q;
    assign nocontext_o       = noctx_q;
    assign notime_o          = notime_q;
    assign encoder_mode_o    = 1'b0;
    assign addr_mode_o       = {1'b0, full_q};

endmodule
`default_nettype wire
